// File: rtl/wash_program_sequencer.sv
// Multi-run wash program controller: turns a 2-bit PROGRAM into a series of
// machine runs (prewash, main, rinses), pulsing START and tracking WM_STATE.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   PROGRAM, GO       program select and start request (GO taken in idle)
//   ABORT             stop scheduling further runs
//   WM_STATE          machine current state, 0 = machine idle
//   WM_SELECTOR       registered selector to machine
//   WM_START          registered one-cycle start to machine
//   BUSY, DONE, FAULT status: active, completion pulse, sticky ack timeout
//   PHASE             0 none, 1 prewash, 2 main, 3 rinse
//   RINSES_LEFT       rinses remaining including the current one
//   RUNS_DONE         saturating count of completed runs (RUN_COUNTER_EN only)
// Optional feature macro: RUN_COUNTER_EN
module wash_program_sequencer #(
    parameter int RINSE_MAX   = 3,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] PROGRAM,
    input  logic       GO,
    input  logic       ABORT,
    input  logic [2:0] WM_STATE,
    output logic [1:0] WM_SELECTOR,
    output logic       WM_START,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAULT,
    output logic [1:0] PHASE,
    output logic [2:0] RINSES_LEFT
`ifdef RUN_COUNTER_EN
    ,
    output logic [7:0] RUNS_DONE
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_ACK,
        S_RUN,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] PH_NONE  = 2'd0;
    localparam logic [1:0] PH_PRE   = 2'd1;
    localparam logic [1:0] PH_MAIN  = 2'd2;
    localparam logic [1:0] PH_RINSE = 2'd3;

    localparam logic [1:0] P_QUICK  = 2'd0;
    localparam logic [1:0] P_NORMAL = 2'd1;
    localparam logic [1:0] P_HOT    = 2'd2;
    localparam logic [1:0] P_HEAVY  = 2'd3;

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0] HEAVY_RINSES = 3'(RINSE_MAX);

    state_t     state, state_n;
    logic [1:0] prog, prog_n;
    logic [1:0] sel_n;
    logic       start_n;
    logic [1:0] phase_n;
    logic [2:0] rinses_n;
    logic [7:0] cnt, cnt_n;
    logic       abort_pend, pend_n;
    logic       last_run;
    logic       abort_now;

    function automatic logic [1:0] main_sel(input logic [1:0] p);
        logic [1:0] s;
        unique case (p)
            P_QUICK:  s = 2'b00;
            P_NORMAL: s = 2'b10;
            default:  s = 2'b11;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] rinse_load(input logic [1:0] p);
        logic [2:0] r;
        unique case (p)
            P_QUICK:  r = 3'd1;
            P_NORMAL: r = 3'd2;
            P_HOT:    r = 3'd2;
            default:  r = HEAVY_RINSES;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n   = state;
        prog_n    = prog;
        sel_n     = WM_SELECTOR;
        start_n   = 1'b0;
        phase_n   = PHASE;
        rinses_n  = RINSES_LEFT;
        cnt_n     = cnt;
        pend_n    = abort_pend;
        last_run  = (PHASE == PH_RINSE) && (RINSES_LEFT == 3'd1);
        abort_now = abort_pend || ABORT;

        unique case (state)
            S_IDLE: begin
                if (GO && !ABORT) begin
                    prog_n   = PROGRAM;
                    rinses_n = rinse_load(PROGRAM);
                    if (PROGRAM == P_HEAVY) begin
                        phase_n = PH_PRE;
                        sel_n   = 2'b01;
                    end else begin
                        phase_n = PH_MAIN;
                        sel_n   = main_sel(PROGRAM);
                    end
                    state_n = S_ARM;
                end
            end
            S_ARM: begin
                if (ABORT) begin
                    state_n = S_IDLE;
                end else if (WM_STATE == 3'd0) begin
                    start_n = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // abort is only remembered here; the run may already be starting
                if (ABORT) pend_n = 1'b1;
                if (WM_STATE != 3'd0) begin
                    state_n = S_RUN;
                end else if (cnt == ACK_LAST) begin
                    state_n = S_FAULT;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_RUN: begin
                if (ABORT) pend_n = 1'b1;
                if (WM_STATE == 3'd0) begin
                    if (abort_now) begin
                        state_n = S_IDLE;
                    end else if (last_run) begin
                        state_n = S_DONE;
                    end else begin
                        unique case (PHASE)
                            PH_PRE: begin
                                phase_n = PH_MAIN;
                                sel_n   = main_sel(prog);
                            end
                            PH_MAIN: begin
                                phase_n = PH_RINSE;
                                sel_n   = 2'b00;
                            end
                            default: begin
                                sel_n    = 2'b00;
                                rinses_n = RINSES_LEFT - 3'd1;
                            end
                        endcase
                        cnt_n   = 8'd0;
                        state_n = (GAP_CYCLES == 0) ? S_ARM : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (ABORT) begin
                    state_n = S_IDLE;
                end else if (cnt == GAP_LAST) begin
                    state_n = S_ARM;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_FAULT: begin
                if (ABORT) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // everything run-related is wiped on the way into idle
        if (state_n == S_IDLE) begin
            sel_n    = 2'b00;
            phase_n  = PH_NONE;
            rinses_n = 3'd0;
            cnt_n    = 8'd0;
            pend_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prog        <= 2'b00;
            WM_SELECTOR <= 2'b00;
            WM_START    <= 1'b0;
            PHASE       <= PH_NONE;
            RINSES_LEFT <= 3'd0;
            cnt         <= 8'd0;
            abort_pend  <= 1'b0;
        end else begin
            state       <= state_n;
            prog        <= prog_n;
            WM_SELECTOR <= sel_n;
            WM_START    <= start_n;
            PHASE       <= phase_n;
            RINSES_LEFT <= rinses_n;
            cnt         <= cnt_n;
            abort_pend  <= pend_n;
        end
    end

    assign BUSY  = (state != S_IDLE) && (state != S_FAULT);
    assign DONE  = (state == S_DONE);
    assign FAULT = (state == S_FAULT);

`ifdef RUN_COUNTER_EN
    logic run_end;

    assign run_end = (state == S_RUN) && (WM_STATE == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RUNS_DONE <= 8'd0;
        end else if (run_end && (RUNS_DONE != 8'hFF)) begin
            RUNS_DONE <= RUNS_DONE + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Scoreboard bench for wash_program_sequencer with a simple machine model.
// Expected START/DONE/FAULT events are queued by stimulus, checked by a monitor.
module tb_wash_program_sequencer;

    localparam int RUN_LEN = 20;

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_FAULT = 2'd2;

    localparam logic [1:0] QUICK  = 2'd0;
    localparam logic [1:0] NORMAL = 2'd1;
    localparam logic [1:0] HOT    = 2'd2;
    localparam logic [1:0] HEAVY  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] sel;
        logic [1:0] phase;
        logic [2:0] rinses;
        int         dly;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] PROGRAM;
    logic       GO;
    logic       ABORT;
    logic [2:0] wm_state;
    logic [1:0] WM_SELECTOR;
    logic       WM_START;
    logic       BUSY;
    logic       DONE;
    logic       FAULT;
    logic [1:0] PHASE;
    logic [2:0] RINSES_LEFT;
`ifdef RUN_COUNTER_EN
    logic [7:0] RUNS_DONE;
`endif

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  mark     = 0;
    int  remaining = 0;
    bit  dead     = 1'b0;
    logic fault_q = 1'b0;
    ev_t exp_q[$];

    wash_program_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .PROGRAM(PROGRAM),
        .GO(GO),
        .ABORT(ABORT),
        .WM_STATE(wm_state),
        .WM_SELECTOR(WM_SELECTOR),
        .WM_START(WM_START),
        .BUSY(BUSY),
        .DONE(DONE),
        .FAULT(FAULT),
        .PHASE(PHASE),
        .RINSES_LEFT(RINSES_LEFT)
`ifdef RUN_COUNTER_EN
        ,
        .RUNS_DONE(RUNS_DONE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic exp_start(input logic [1:0] s, input logic [1:0] p,
                             input logic [2:0] r, input int d);
        ev_t e;
        e.kind = K_START; e.sel = s; e.phase = p; e.rinses = r; e.dly = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_other(input logic [1:0] k, input int d);
        ev_t e;
        e = '0;
        e.kind = k;
        e.dly  = d;
        exp_q.push_back(e);
    endtask

    // called at a negedge: GO for one cycle, delays are measured from here
    task automatic start_prog(input logic [1:0] p);
        GO = 1'b1;
        PROGRAM = p;
        mark = cyc;
        @(negedge clk);
        GO = 1'b0;
    endtask

    // machine model: leaves idle on START, returns after RUN_LEN cycles
    always @(negedge clk) begin
        if (remaining > 0) begin
            remaining--;
            if (remaining == 0) wm_state = 3'd0;
        end else if (WM_START && !dead) begin
            wm_state  = 3'd1;
            remaining = RUN_LEN;
        end
    end

    // monitor
    always @(negedge clk) begin
        ev_t  a;
        ev_t  e;
        logic hit;
        hit = 1'b0;
        a   = '0;
        if (WM_START) begin
            hit = 1'b1;
            a.kind = K_START;
            a.sel = WM_SELECTOR;
            a.phase = PHASE;
            a.rinses = RINSES_LEFT;
        end else if (DONE) begin
            hit = 1'b1;
            a.kind = K_DONE;
        end else if (FAULT && !fault_q) begin
            hit = 1'b1;
            a.kind = K_FAULT;
        end
        fault_q = FAULT;
        if (hit) begin
            a.dly = cyc - mark;
            mark  = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d sel %0d at cycle %0d, required none",
                         a.kind, a.sel, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_sel_phase_rinses",
                      32'({a.kind, a.sel, a.phase, a.rinses}),
                      32'({e.kind, e.sel, e.phase, e.rinses}));
                check("event_delay", a.dly, e.dly);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        GO = 1'b0;
        ABORT = 1'b0;
        PROGRAM = 2'b00;
        wm_state = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_start", 32'(WM_START), 0);
        check("rst_sel", 32'(WM_SELECTOR), 0);
        check("rst_phase", 32'(PHASE), 0);
        check("rst_rinses", 32'(RINSES_LEFT), 0);
        check("rst_done_fault", 32'({DONE, FAULT}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // QUICK
        exp_start(2'b00, 2'd2, 3'd1, 2);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        exp_other(K_DONE, 21);
        start_prog(QUICK);
        repeat (55) @(negedge clk);
        check("quick_busy_after", 32'(BUSY), 0);
        check("quick_phase_after", 32'(PHASE), 0);

        // HEAVY
        exp_start(2'b01, 2'd1, 3'd3, 2);
        exp_start(2'b11, 2'd2, 3'd3, 30);
        exp_start(2'b00, 2'd3, 3'd3, 30);
        exp_start(2'b00, 2'd3, 3'd2, 30);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        exp_other(K_DONE, 21);
        start_prog(HEAVY);
        repeat (150) @(negedge clk);
        check("heavy_busy_after", 32'(BUSY), 0);

        // machine never acknowledges
        dead = 1'b1;
        exp_start(2'b00, 2'd2, 3'd1, 2);
        exp_other(K_FAULT, 16);
        start_prog(QUICK);
        repeat (25) @(negedge clk);
        check("fault_high", 32'(FAULT), 1);
        check("fault_busy", 32'(BUSY), 0);
        check("fault_start", 32'(WM_START), 0);
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        check("fault_cleared", 32'(FAULT), 0);
        check("fault_idle_busy", 32'(BUSY), 0);
        dead = 1'b0;
        repeat (3) @(negedge clk);

        // NORMAL aborted during the main run
        exp_start(2'b10, 2'd2, 3'd2, 2);
        start_prog(NORMAL);
        repeat (11) @(negedge clk);
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_last_run_cycle", 32'(BUSY), 1);
        @(negedge clk);
        check("abort_idle_busy", 32'(BUSY), 0);
        check("abort_idle_sel", 32'(WM_SELECTOR), 0);
        repeat (40) @(negedge clk);

        // HOT with GO held: runs, completes, restarts after DONE
        exp_start(2'b11, 2'd2, 3'd2, 2);
        exp_start(2'b00, 2'd3, 3'd2, 30);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        exp_other(K_DONE, 21);
        exp_start(2'b11, 2'd2, 3'd2, 3);
        exp_start(2'b00, 2'd3, 3'd2, 30);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        exp_other(K_DONE, 21);
        GO = 1'b1;
        PROGRAM = HOT;
        mark = cyc;
        repeat (90) @(negedge clk);
        GO = 1'b0;
        repeat (90) @(negedge clk);
        check("hot_busy_after", 32'(BUSY), 0);

        // GO and ABORT together in idle
        GO = 1'b1;
        ABORT = 1'b1;
        PROGRAM = QUICK;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("go_abort_busy", 32'(BUSY), 0);
        end
        GO = 1'b0;
        ABORT = 1'b0;
        repeat (10) @(negedge clk);

        // reset during the rinse
        exp_start(2'b00, 2'd2, 3'd1, 2);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        start_prog(QUICK);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(BUSY), 0);
        check("midrst_start", 32'(WM_START), 0);
        check("midrst_sel", 32'(WM_SELECTOR), 0);
        check("midrst_phase", 32'(PHASE), 0);
        check("midrst_rinses", 32'(RINSES_LEFT), 0);
        check("midrst_done_fault", 32'({DONE, FAULT}), 0);
`ifdef RUN_COUNTER_EN
        check("midrst_runs_done", 32'(RUNS_DONE), 0);
`endif
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        // full NORMAL program
        exp_start(2'b10, 2'd2, 3'd2, 2);
        exp_start(2'b00, 2'd3, 3'd2, 30);
        exp_start(2'b00, 2'd3, 3'd1, 30);
        exp_other(K_DONE, 21);
        start_prog(NORMAL);
        repeat (90) @(negedge clk);
        check("normal_busy_after", 32'(BUSY), 0);
`ifdef RUN_COUNTER_EN
        check("normal_runs_done", 32'(RUNS_DONE), 3);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
